// File: rtl/config_loader.sv
// -----------------------------------------------------------------------------
// config_loader
//   Bitstream loader that sits directly upstream of the tile configuration
//   chain. Configuration words arrive over a valid/ready stream and are
//   serialised LSB-first onto the chain head. Each load:
//     1. holds chain_nreset low for CLEAR_CYCLES cycles,
//     2. shifts exactly CHAIN_LENGTH bits (chain_enable high once per bit),
//     3. pulses done for one cycle and returns to idle.
//   A one-word skid buffer sits in front of the shift register so the next
//   word can be taken while the current one is still shifting out; with a
//   source that keeps up, the bit stream has no bubbles.
//
// Ports
//   config_clock  in   shared clock for loader and chain
//   config_reset  in   synchronous, active-high reset
//   start         in   one-cycle pulse, begins a load when idle
//   word_data     in   bitstream word, bit 0 shifted first
//   word_valid    in   word_data valid
//   word_ready    out  word accepted on a cycle with word_valid & word_ready
//   chain_data    out  serial bit to chain head
//   chain_enable  out  chain shift enable, high only for real bits
//   chain_nreset  out  active-low chain clear
//   busy          out  load in progress (CLEAR or STREAM)
//   done          out  one-cycle pulse after the final bit
//   error         out  sticky, start seen while busy
//   dbg_state     out  current FSM state (IDLE=0, CLEAR=1, STREAM=2, DONE=3)
//
// Handshake: a word transfers on every rising edge where word_valid and
// word_ready are both high. word_ready never depends on word_valid, and the
// source must hold word_data stable while word_valid is high and not taken.
// -----------------------------------------------------------------------------
module config_loader #(
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_LENGTH = 2304,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic                  config_clock,
  input  logic                  config_reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  chain_data,
  output logic                  chain_enable,
  output logic                  chain_nreset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            dbg_state
);

  localparam int CNT_W = $clog2(CHAIN_LENGTH + 1);
  localparam int SC_W  = $clog2(WORD_WIDTH + 1);
  localparam int CC_W  = $clog2(CLEAR_CYCLES + 1);

  localparam logic [CNT_W-1:0] NUM_WORDS  =
    CNT_W'((CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH);
  localparam logic [CNT_W-1:0] TOTAL_BITS = CNT_W'(CHAIN_LENGTH);
  localparam logic [SC_W-1:0]  FULL_WORD  = SC_W'(WORD_WIDTH);
  localparam logic [CC_W-1:0]  CLEAR_LAST = CC_W'(CLEAR_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLEAR  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]            r_state;
  logic [CC_W-1:0]       r_clear_cnt;
  logic [WORD_WIDTH-1:0] r_shift;
  logic [SC_W-1:0]       r_shift_cnt;   // valid bits left in r_shift
  logic [WORD_WIDTH-1:0] r_skid;
  logic                  r_skid_valid;
  logic [CNT_W-1:0]      r_words_left;  // words still to accept this load
  logic [CNT_W-1:0]      r_bits_left;   // chain bits still to shift this load
  logic                  r_error;

  logic w_busy;
  logic w_shift;
  logic w_accept;
  logic w_last_bit;
  logic w_shift_empty_next;

  assign w_busy     = (r_state == ST_CLEAR) || (r_state == ST_STREAM);
  assign w_shift    = (r_state == ST_STREAM) && (r_shift_cnt != '0);
  assign w_last_bit = w_shift && (r_bits_left == CNT_W'(1));
  assign word_ready = w_busy && !r_skid_valid && (r_words_left != '0);
  assign w_accept   = word_valid && word_ready;

  // The shift register is free to take a new word on the next edge when it
  // is already empty or is emitting its final valid bit this cycle.
  assign w_shift_empty_next = (r_shift_cnt == '0) ||
                              (w_shift && (r_shift_cnt == SC_W'(1)));

  assign chain_enable = w_shift;
  assign chain_data   = w_shift & r_shift[0];
  assign chain_nreset = (r_state != ST_CLEAR);
  assign busy         = w_busy;
  assign done         = (r_state == ST_DONE);
  assign error        = r_error;
  assign dbg_state    = r_state;

  always_ff @(posedge config_clock) begin
    if (config_reset) begin
      r_state      <= ST_IDLE;
      r_clear_cnt  <= '0;
      r_shift      <= '0;
      r_shift_cnt  <= '0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
      r_words_left <= '0;
      r_bits_left  <= '0;
      r_error      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state      <= ST_CLEAR;
            r_clear_cnt  <= CLEAR_LAST;
            r_words_left <= NUM_WORDS;
            r_bits_left  <= TOTAL_BITS;
            r_shift_cnt  <= '0;
            r_skid_valid <= 1'b0;
            r_error      <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (r_clear_cnt == '0) begin
            r_state <= ST_STREAM;
          end else begin
            r_clear_cnt <= r_clear_cnt - CC_W'(1);
          end
        end
        ST_STREAM: begin
          // Leaving on the final counted bit discards any unused upper bits
          // of a partial last word without ever enabling them.
          if (w_last_bit) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      // start during DONE is deliberately ignored without raising error.
      if (start && w_busy) begin
        r_error <= 1'b1;
      end

      if (w_accept) begin
        r_words_left <= r_words_left - CNT_W'(1);
      end

      if (w_shift) begin
        r_bits_left <= r_bits_left - CNT_W'(1);
      end

      if (w_busy) begin
        if (w_shift_empty_next) begin
          if (r_skid_valid) begin
            // word_ready is low while the skid holds a word, so no new word
            // can arrive on this edge; the skid simply drains.
            r_shift      <= r_skid;
            r_shift_cnt  <= FULL_WORD;
            r_skid_valid <= 1'b0;
          end else if (w_accept) begin
            r_shift     <= word_data;
            r_shift_cnt <= FULL_WORD;
          end else begin
            r_shift_cnt <= '0;
          end
        end else begin
          if (w_shift) begin
            r_shift     <= r_shift >> 1;
            r_shift_cnt <= r_shift_cnt - SC_W'(1);
          end
          if (w_accept) begin
            r_skid       <= word_data;
            r_skid_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// -----------------------------------------------------------------------------
// tb_config_loader
//   Directed bench for config_loader. Main instance: WORD_WIDTH=8,
//   CHAIN_LENGTH=36, CLEAR_CYCLES=4. Second instance: WORD_WIDTH=32,
//   CHAIN_LENGTH=32, CLEAR_CYCLES=4. Cycle 0 of a load is the cycle in which
//   start is driven high; the clear window is cycles 1..4 and the first
//   enabled bit appears on cycle 5.
// -----------------------------------------------------------------------------
module tb_config_loader;

  localparam int WW = 8;
  localparam int CL = 36;
  localparam int CC = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          config_reset;
  logic          start;
  logic [WW-1:0] word_data;
  logic          word_valid;
  logic          word_ready;
  logic          chain_data;
  logic          chain_enable;
  logic          chain_nreset;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    dbg_state;

  logic          b_start;
  logic [31:0]   b_data;
  logic          b_valid;
  logic          b_ready;
  logic          b_cdata;
  logic          b_cen;
  logic          b_nreset;
  logic          b_busy;
  logic          b_done;
  logic          b_error;
  logic [1:0]    b_dbg;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard of expected serial bits for the current load
  logic [0:0] exp_q[$];
  logic [WW-1:0] src_w [5];

  config_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL), .CLEAR_CYCLES(CC)) u_dut (
    .config_clock (clk),
    .config_reset (config_reset),
    .start        (start),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .chain_data   (chain_data),
    .chain_enable (chain_enable),
    .chain_nreset (chain_nreset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .dbg_state    (dbg_state)
  );

  config_loader #(.WORD_WIDTH(32), .CHAIN_LENGTH(32), .CLEAR_CYCLES(4)) u_dut_wide (
    .config_clock (clk),
    .config_reset (config_reset),
    .start        (b_start),
    .word_data    (b_data),
    .word_valid   (b_valid),
    .word_ready   (b_ready),
    .chain_data   (b_cdata),
    .chain_enable (b_cen),
    .chain_nreset (b_nreset),
    .busy         (b_busy),
    .done         (b_done),
    .error        (b_error),
    .dbg_state    (b_dbg)
  );

  // ---------------- checker ----------------
  task automatic check1(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- driver: one full load on the main instance ----------------
  // hold_idx/hold_until: word index withheld (valid low) until that cycle
  // xstart_cyc/xstart_err: extra start pulse and whether it should set error
  // reset_cyc: cycle in which config_reset is driven high (-1 none)
  // exp_done: expected done cycle (-1 none)
  task automatic run_load(input int hold_idx, input int hold_until,
                          input int xstart_cyc, input logic xstart_err,
                          input int reset_cyc, input int exp_gaps,
                          input int exp_done, input int exp_en,
                          input logic [35:0] exp_image);
    int cyc, idx, en_cnt, gaps, nrl, done_cnt, done_cyc, first_en;
    logic [35:0] cap;
    logic acc, exp_busy, exp_err;
    logic [0:0] eb;
    bit fin;

    exp_q.delete();
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < WW; b++) begin
        if (w * WW + b < CL) exp_q.push_back(src_w[w][b]);
      end
    end

    cyc = 0; idx = 0; en_cnt = 0; gaps = 0; nrl = 0; done_cnt = 0;
    done_cyc = -1; first_en = -1; cap = '0; fin = 0;
    start = 1'b1; word_valid = 1'b1; word_data = src_w[0];

    while (!fin && cyc < 200) begin
      @(negedge clk);
      if (reset_cyc >= 0 && cyc == reset_cyc + 1) begin
        check1("rst_word_ready", word_ready, 1'b0);
        check1("rst_chain_enable", chain_enable, 1'b0);
        check1("rst_chain_data", chain_data, 1'b0);
        check1("rst_chain_nreset", chain_nreset, 1'b1);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_error", error, 1'b0);
        check1("rst_state", dbg_state, 2'd0);
        fin = 1;
      end else begin
        if (done) begin
          done_cnt++;
          if (done_cyc < 0) done_cyc = cyc;
        end
        if (chain_enable) begin
          if (first_en < 0) first_en = cyc;
          en_cnt++;
          cap = {chain_data, cap[35:1]};
          if (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            check1("chain_bit", chain_data, eb);
          end else begin
            check1("extra_enable", 1'b1, 1'b0);
          end
        end else begin
          if (first_en >= 0 && done_cyc < 0) gaps++;
          check1("stall_data_zero", chain_data, 1'b0);
        end
        if (!chain_nreset) begin
          nrl++;
          check1("nreset_window", (cyc >= 1 && cyc <= CC), 1'b1);
        end
        if (idx == 5) check1("ready_after_all", word_ready, 1'b0);
        exp_busy = (cyc >= 1) && (exp_done < 0 || cyc < exp_done);
        check1("busy", busy, exp_busy);
        if (cyc >= 1) begin
          exp_err = (xstart_cyc >= 0) && xstart_err && (cyc > xstart_cyc);
          check1("error", error, exp_err);
        end
        if (cyc == 1) check1("state_clear", dbg_state, 2'd1);
        if (cyc == 5) check1("state_stream", dbg_state, 2'd2);
        if (cyc == exp_done) check1("state_done", dbg_state, 2'd3);
        acc = word_valid & word_ready;
        if (done_cyc >= 0 && cyc == done_cyc + 1) fin = 1;
      end
      if (!fin) begin
        @(posedge clk);
        #1;
        cyc++;
        start = (cyc == xstart_cyc);
        config_reset = (cyc == reset_cyc);
        if (acc) idx++;
        // After the last word the source keeps offering a dummy word,
        // which must never be consumed.
        word_valid = (idx >= 5) || !(idx == hold_idx && cyc < hold_until);
        word_data  = (idx < 5) ? src_w[idx] : 8'h77;
      end
    end
    if (!fin) check1("load_timeout", 1'b0, 1'b1);

    start = 1'b0; config_reset = 1'b0; word_valid = 1'b0; word_data = '0;
    check1("enable_count", en_cnt, exp_en);
    check1("stall_gaps", gaps, exp_gaps);
    check1("done_cycle", done_cyc, exp_done);
    check1("done_pulses", done_cnt, (exp_done >= 0) ? 1 : 0);
    check1("nreset_low_cycles", nrl, CC);
    if (exp_done >= 0) begin
      check1("first_enable_cycle", first_en, 5);
      check1("capture_image", cap, exp_image);
      check1("scoreboard_empty", exp_q.size(), 0);
    end
    idle(2);
  endtask

  // ---------------- driver: single-word load on the wide instance ----------------
  task automatic run_wide();
    logic [31:0] w, cap;
    int cyc, en_cnt, done_cyc, idx;
    logic acc;
    bit fin;
    w = 32'hDEADBEEF; cap = '0; cyc = 0; en_cnt = 0; done_cyc = -1; idx = 0; fin = 0;
    b_start = 1'b1; b_valid = 1'b1; b_data = w;
    while (!fin && cyc < 100) begin
      @(negedge clk);
      if (b_cen) begin
        if (en_cnt < 32) check1("wide_bit", b_cdata, w[en_cnt]);
        else check1("wide_extra_enable", 1'b1, 1'b0);
        en_cnt++;
        cap = {b_cdata, cap[31:1]};
      end
      if (b_done && done_cyc < 0) done_cyc = cyc;
      if (idx == 1) check1("wide_ready_after_all", b_ready, 1'b0);
      acc = b_valid & b_ready;
      if (done_cyc >= 0) fin = 1;
      else begin
        @(posedge clk);
        #1;
        cyc++;
        b_start = 1'b0;
        if (acc) idx++;
        b_data = (idx == 0) ? w : 32'h12345678;
      end
    end
    if (!fin) check1("wide_timeout", 1'b0, 1'b1);
    b_valid = 1'b0; b_start = 1'b0;
    check1("wide_enable_count", en_cnt, 32);
    check1("wide_done_cycle", done_cyc, 37);
    check1("wide_capture", cap, 32'hDEADBEEF);
    check1("wide_error", b_error, 1'b0);
    idle(2);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    config_reset = 1'b1; start = 1'b0; word_valid = 1'b0; word_data = '0;
    b_start = 1'b0; b_valid = 1'b0; b_data = '0;
    repeat (3) @(posedge clk);
    #1;
    config_reset = 1'b0;
    @(negedge clk);
    check1("reset_word_ready", word_ready, 1'b0);
    check1("reset_chain_enable", chain_enable, 1'b0);
    check1("reset_chain_data", chain_data, 1'b0);
    check1("reset_chain_nreset", chain_nreset, 1'b1);
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check1("reset_error", error, 1'b0);
    check1("reset_state", dbg_state, 2'd0);
    check1("reset_wide_nreset", b_nreset, 1'b1);
    check1("reset_wide_busy", b_busy, 1'b0);
    check1("reset_wide_state", b_dbg, 2'd0);
    idle(1);

    // Continuous source, 36 contiguous bits, done on cycle 4+1+36 = 41
    src_w[0] = 8'hA5; src_w[1] = 8'h3C; src_w[2] = 8'hFF;
    src_w[3] = 8'h01; src_w[4] = 8'h0E;
    run_load(-1, 0, -1, 1'b0, -1, 0, 41, 36, 36'hE01FF3CA5);

    // Third word withheld until cycle 23: shift empties after cycle 20,
    // so cycles 21..23 stall; last word 0xFE contributes only 0,1,1,1
    src_w[4] = 8'hFE;
    run_load(2, 23, -1, 1'b0, -1, 3, 44, 36, 36'hE01FF3CA5);

    // start at STREAM cycle 10 (cycle 15): error sticky, load unaffected
    src_w[4] = 8'h0E;
    run_load(-1, 0, 15, 1'b1, -1, 0, 41, 36, 36'hE01FF3CA5);

    // New start from IDLE clears error; start during DONE is ignored
    run_load(-1, 0, 41, 1'b0, -1, 0, 41, 36, 36'hE01FF3CA5);

    // Reset at STREAM cycle 20 (cycle 25): 21 bits went out (cycles 5..25)
    run_load(-1, 0, -1, 1'b0, 25, 0, -1, 21, 36'h0);

    // Clean full load after the abort
    run_load(-1, 0, -1, 1'b0, -1, 0, 41, 36, 36'hE01FF3CA5);

    // 32-bit word, 32-bit chain: done on cycle 4+1+32 = 37
    run_wide();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Bitstream loader directly upstream of the tile configuration chain.
- Accepts configuration words over a valid/ready stream and serialises them LSB-first onto the head of the chain, driving the chain's data input, shift enable and active-low clear.
- Shifts exactly CHAIN_LENGTH bits per load, then flags done.
- A one-word skid buffer lets words arrive while the current word is shifting, so the shift stream has no bubbles when the source keeps up.

Parameters:
- WORD_WIDTH, 32, width of each incoming bitstream word.
- CHAIN_LENGTH, 2304, total config bits in the chain (sum of all tile shift registers); must be >= 1.
- CLEAR_CYCLES, 4, cycles chain_nreset is held low at start of a load; must be >= 1.

Ports:
- config_clock  input  1  single clock; loader and chain share it.
- config_reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load when idle.
- word_data  input  WORD_WIDTH  bitstream word; bit 0 is shifted first.
- word_valid  input  1  word_data valid.
- word_ready  output  1  loader accepts word this cycle when valid&ready.
- chain_data  output  1  serial bit to chain head config_in.
- chain_enable  output  1  chain shift enable; high only on cycles chain_data is a real bit.
- chain_nreset  output  1  active-low chain clear.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the last bit has been shifted.
- error  output  1  sticky; set on start while busy; cleared by the next accepted start or reset.

Behaviour:
- Reset (sampled on config_clock edge while config_reset=1) forces:
  - state IDLE; word_ready=0, chain_data=0, chain_enable=0, chain_nreset=1, busy=0, done=0, error=0.
  - Bit counter, word counter and both buffers cleared.
- Reset mid-load aborts immediately; no further chain_enable pulses; the chain keeps partial content.
- States: IDLE -> CLEAR -> STREAM -> DONE -> IDLE.
- IDLE: start=1 -> CLEAR next cycle, busy=1, error cleared.
- CLEAR: chain_nreset=0 for exactly CLEAR_CYCLES cycles. word_ready=1 if the skid buffer is empty, so the first word may be preloaded. Then -> STREAM.
- STREAM:
  - Shift register holds the current word. Each cycle it holds a valid bit: chain_data=bit, chain_enable=1, shift right by 1, remaining-bit counter decrements.
  - When the shift register empties and the skid buffer is full, the buffer transfers in the same cycle, so there is no gap.
  - If both are empty, chain_enable=0 and chain_data=0 (stall) until a word arrives.
  - Transfer latency: word accepted into an empty shift register on cycle N -> its bit 0 on chain_data with chain_enable=1 on cycle N+1.
- word_ready=1 only when busy, the skid buffer is empty, and words still to accept > 0.
  - Words to accept = ceil(CHAIN_LENGTH/WORD_WIDTH), counted from start.
  - Once all words are accepted, word_ready stays 0; extra valid words are not consumed.
- Last word partial: only the CHAIN_LENGTH mod WORD_WIDTH low bits are shifted (all bits if mod=0); upper bits are discarded, with no enable for them.
- Exactly CHAIN_LENGTH chain_enable=1 cycles per load, counted inclusive of stalls.
- Cycle after the final enabled bit: state DONE, done=1 for one cycle, busy=0, chain_enable=0 -> IDLE.
- start while busy: ignored, error=1. start in DONE cycle: ignored, no error. start in the same cycle as reset: reset wins.
- Counters are sized ceil(log2(CHAIN_LENGTH+1)) bits; no wrap-around is permitted.

Test Plan:
- Override WORD_WIDTH=8, CHAIN_LENGTH=36, CLEAR_CYCLES=4. Start, then continuous valid words 0xA5,0x3C,0xFF,0x01,0x0E -> chain_nreset low 4 cycles; 36 contiguous enable cycles with no gaps; bitstream LSB-first 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0,… ending with 0,1,1,1; done pulses once; word_ready never high after the 5th accept.
- Same load, word_valid deasserted for 3 cycles after word 2 -> chain_enable drops for exactly those stall cycles; total enable count is still 36; a 36-bit capture model behind the chain matches the expected image.
- Last word 0xFE with mod=4 -> only bits 1,1,1,0 (bit 0 first: 0,1,1,1) shifted; upper nibble never enabled.
- Pulse start at STREAM cycle 10 -> error=1 and stays set; load completes normally; next start from IDLE clears error.
- Assert config_reset at STREAM cycle 20 -> next cycle all outputs at reset values; a subsequent start performs a full clean load.
- CHAIN_LENGTH=32, WORD_WIDTH=32, single word 0xDEADBEEF -> exactly 32 enables; done at clear+1+32 cycles after start.
